apb_slave_mem_resp: RTL and testbench

Synthesisable APB slave responder with a parametrised word-addressed backing memory, programmable per-transfer wait states, address-decode error response and forced-error injection. It generalises the APB slave VIP interface into an RTL model. Widths, depth and base address are parameters, and APB4 byte strobes are optional. It sits behind the axi2apb bridge as the DUT-side APB target in both block-level and FPGA benches.

---
 rtl/apb_slave_mem_resp_pkg.sv | 27 ++
 rtl/apb_slave_mem_resp_if.sv | 41 ++++
 rtl/apb_slave_mem_resp_mem.sv | 31 +++
 rtl/apb_slave_mem_resp.sv | 141 ++++++++++++++
 tb/tb_apb_slave_mem_resp.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_slave_mem_resp_pkg.sv
// Shared types and helpers for the APB slave memory responder.
// Byte strobes are enabled by defining APB_SLV_PSTRB_EN.
package apb_slv_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_slv_state_e;

    localparam int unsigned ACCESS_CNT_W = 16;

    // Strobe width for a given data width
    function automatic int unsigned strb_w(input int unsigned data_width);
        return data_width / 8;
    endfunction

    // Address decode: out of window below/above, or not word aligned
    function automatic logic addr_err(
        input logic [63:0] addr,
        input logic [63:0] base,
        input logic [63:0] span,
        input logic [63:0] align_mask
    );
        return (addr < base) || (addr >= (base + span)) || ((addr & align_mask) != 64'd0);
    endfunction

endpackage

// File: rtl/apb_slave_mem_resp_if.sv
// APB bus bundle between a master and the memory responder.
// pstrb exists only when APB_SLV_PSTRB_EN is defined.
interface apb_slave_mem_resp_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB_W = apb_slv_pkg::strb_w(DATA_WIDTH);

    logic [ADDR_WIDTH-1:0] paddr;
    logic                  pwrite;
    logic                  psel;
    logic                  penable;
    logic [DATA_WIDTH-1:0] pwdata;
`ifdef APB_SLV_PSTRB_EN
    logic [STRB_W-1:0]     pstrb;
`endif
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

`ifdef APB_SLV_PSTRB_EN
    modport master (
        output paddr, pwrite, psel, penable, pwdata, pstrb,
        input  prdata, pready, pslverr
    );
    modport slave (
        input  paddr, pwrite, psel, penable, pwdata, pstrb,
        output prdata, pready, pslverr
    );
`else
    modport master (
        output paddr, pwrite, psel, penable, pwdata,
        input  prdata, pready, pslverr
    );
    modport slave (
        input  paddr, pwrite, psel, penable, pwdata,
        output prdata, pready, pslverr
    );
`endif

endinterface

// File: rtl/apb_slave_mem_resp_mem.sv
// Word-addressed backing store: synchronous byte-enabled write, asynchronous read.
module apb_slv_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 256
) (
    input  logic                            clk,
    input  logic                            we,
    input  logic [$clog2(DEPTH)-1:0]        waddr,
    input  logic [DATA_WIDTH-1:0]           wdata,
    input  logic [DATA_WIDTH/8-1:0]         wstrb,
    input  logic [$clog2(DEPTH)-1:0]        raddr,
    output logic [DATA_WIDTH-1:0]           rdata
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (wstrb[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_mem_resp.sv
// APB slave responder: memory, programmable wait states, decode/injected errors.
// Define APB_SLV_PSTRB_EN to honour per-byte write strobes.
module apb_slave_mem_resp
    import apb_slv_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter int unsigned            DATA_WIDTH = 32,
    parameter int unsigned            DEPTH      = 256,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0,
    parameter int unsigned            MAX_WAIT   = 15,
    localparam int unsigned           WAIT_W     = $clog2(MAX_WAIT + 1)
) (
    input  logic                     APB_ACLK,
    input  logic                     APB_ARESET,
    apb_slave_mem_resp_if.slave      bus,
    input  logic [WAIT_W-1:0]        wait_cfg,
    input  logic                     err_inject,
    output logic [ACCESS_CNT_W-1:0]  access_cnt
);
    localparam int unsigned STRB_W = strb_w(DATA_WIDTH);
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned SPAN   = DEPTH * STRB_W;

    apb_slv_state_e         state;
    apb_slv_state_e         state_n;
    logic                   setup_c;
    logic                   pready_c;

    logic [WAIT_W-1:0]      cnt;
    logic [WAIT_W-1:0]      wait_ld;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       lat_idx;
    logic                   lat_write;
    logic [DATA_WIDTH-1:0]  lat_wdata;
    logic [STRB_W-1:0]      lat_strb;
    logic [STRB_W-1:0]      strb_in;
    logic                   err_dec;
    logic                   err_flag;
    logic [DATA_WIDTH-1:0]  prdata_q;
    logic [DATA_WIDTH-1:0]  mem_rdata;
    logic                   mem_we;

    // Setup-phase decode from the live bus
    assign err_dec = err_inject |
                     addr_err(64'(bus.paddr), 64'(BASE_ADDR), 64'(SPAN), 64'(STRB_W - 1));
    assign idx     = IDX_W'((bus.paddr - BASE_ADDR) >> OFF_W);
    assign wait_ld = (32'(wait_cfg) > MAX_WAIT) ? WAIT_W'(MAX_WAIT) : wait_cfg;

`ifdef APB_SLV_PSTRB_EN
    assign strb_in = bus.pstrb;
`else
    assign strb_in = '1;
`endif

    always_ff @(posedge APB_ACLK) begin
        if (APB_ARESET) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        setup_c  = 1'b0;
        pready_c = 1'b0;
        case (state)
            IDLE: begin
                if (bus.psel && !bus.penable) begin
                    setup_c = 1'b1;
                    state_n = ACCESS;
                end
            end
            ACCESS: begin
                // Dropping psel mid-transfer abandons it silently
                if (!bus.psel) begin
                    state_n = IDLE;
                end else if (bus.penable && (cnt == '0)) begin
                    pready_c = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Wait counter, error flag, read data and completion counter
    always_ff @(posedge APB_ACLK) begin
        if (APB_ARESET) begin
            cnt        <= '0;
            err_flag   <= 1'b0;
            prdata_q   <= '0;
            access_cnt <= '0;
        end else begin
            if (setup_c) begin
                cnt      <= wait_ld;
                err_flag <= err_dec;
                if (!bus.pwrite) begin
                    prdata_q <= err_dec ? '0 : mem_rdata;
                end
            end else if ((state == ACCESS) && bus.psel && bus.penable && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            if (pready_c && (access_cnt != '1)) begin
                access_cnt <= access_cnt + 1'b1;
            end
        end
    end

    // Transfer attributes captured at setup; no reset needed
    always_ff @(posedge APB_ACLK) begin
        if (setup_c) begin
            lat_idx   <= idx;
            lat_write <= bus.pwrite;
            lat_wdata <= bus.pwdata;
            lat_strb  <= strb_in;
        end
    end

    // A reset coinciding with completion must not commit the write
    assign mem_we = pready_c & lat_write & ~err_flag & ~APB_ARESET;

    apb_slv_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (APB_ACLK),
        .we    (mem_we),
        .waddr (lat_idx),
        .wdata (lat_wdata),
        .wstrb (lat_strb),
        .raddr (idx),
        .rdata (mem_rdata)
    );

    assign bus.prdata  = prdata_q;
    assign bus.pready  = pready_c;
    assign bus.pslverr = pready_c & err_flag;

endmodule

// File: tb/tb_apb_slave_mem_resp.sv
// Directed self-checking bench for apb_slave_mem_resp (BASE 0x1000, 256 x 32-bit).
// Strobe scenarios run only when APB_SLV_PSTRB_EN is defined.
module tb_apb_slave_mem_resp;

    logic        clk;
    logic        rst;
    logic [3:0]  wait_cfg;
    logic        err_inject;
    logic [15:0] access_cnt;

    int          checks;
    int          errors;
    logic [31:0] rd;
    logic        se;
    int          cyc;
    int          low;
    logic [15:0] exp_cnt;
`ifdef APB_SLV_PSTRB_EN
    logic [3:0]  tb_strb;
`endif

    apb_slave_mem_resp_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb_slave_mem_resp #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .DEPTH      (256),
        .BASE_ADDR  (32'h0000_1000),
        .MAX_WAIT   (15)
    ) dut (
        .APB_ACLK   (clk),
        .APB_ARESET (rst),
        .bus        (bus),
        .wait_cfg   (wait_cfg),
        .err_inject (err_inject),
        .access_cnt (access_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One APB transfer; the next call's setup lands in the cycle after completion
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdat,
                        input logic [3:0] waits, input logic err);
        @(negedge clk);
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = wr;
        bus.paddr   = addr;
        bus.pwdata  = wdat;
`ifdef APB_SLV_PSTRB_EN
        bus.pstrb   = tb_strb;
`endif
        wait_cfg    = waits;
        err_inject  = err;
        @(negedge clk);
        bus.penable = 1'b1;
        wait_cfg    = 4'd15 - waits;
        err_inject  = ~err;
        cyc = 2;
        low = 0;
        #1;
        while (!bus.pready && cyc < 40) begin
            low++;
            @(negedge clk);
            #1;
            cyc++;
        end
        if (!bus.pready) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout addr=%h got pready=%b want 1", addr, bus.pready);
        end else if (exp_cnt != 16'hFFFF) begin
            exp_cnt++;
        end
        rd = bus.prdata;
        se = bus.pslverr;
    endtask

    task automatic go_idle();
        @(negedge clk);
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.pready !== 1'b0)   begin errors++; $display("FAIL rst_pready got %b want 0", bus.pready); end
        checks++; if (bus.pslverr !== 1'b0)  begin errors++; $display("FAIL rst_pslverr got %b want 0", bus.pslverr); end
        checks++; if (bus.prdata !== 32'h0)  begin errors++; $display("FAIL rst_prdata got %h want 0", bus.prdata); end
        checks++; if (access_cnt !== 16'h0)  begin errors++; $display("FAIL rst_access_cnt got %h want 0", access_cnt); end
        rst = 1'b0;
        exp_cnt = 16'h0;
    endtask

    task automatic test_write_read();
        xfer(1'b1, 32'h1010, 32'hDEADBEEF, 4'd0, 1'b0);
        checks++; if (cyc != 2)   begin errors++; $display("FAIL wr_len got %0d want 2", cyc); end
        checks++; if (se !== 1'b0) begin errors++; $display("FAIL wr_slverr got %b want 0", se); end
        xfer(1'b0, 32'h1010, 32'h0, 4'd0, 1'b0);
        checks++; if (cyc != 2)   begin errors++; $display("FAIL rd_len got %0d want 2", cyc); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h want deadbeef", rd); end
        checks++; if (se !== 1'b0) begin errors++; $display("FAIL rd_slverr got %b want 0", se); end
        @(posedge clk); #1;
        checks++; if (access_cnt !== 16'd2) begin errors++; $display("FAIL cnt_after_wr_rd got %0d want 2", access_cnt); end
    endtask

    task automatic test_wait_states();
        xfer(1'b0, 32'h1010, 32'h0, 4'd3, 1'b0);
        checks++; if (cyc != 5)  begin errors++; $display("FAIL wait3_len got %0d want 5", cyc); end
        checks++; if (low != 3)  begin errors++; $display("FAIL wait3_low got %0d want 3", low); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL wait3_data got %h want deadbeef", rd); end
        xfer(1'b0, 32'h1010, 32'h0, 4'd15, 1'b0);
        checks++; if (cyc != 17) begin errors++; $display("FAIL wait15_len got %0d want 17", cyc); end
    endtask

    task automatic test_decode_err();
        xfer(1'b0, 32'h1400, 32'h0, 4'd0, 1'b0);
        checks++; if (se !== 1'b1)    begin errors++; $display("FAIL above_slverr got %b want 1", se); end
        checks++; if (rd !== 32'h0)   begin errors++; $display("FAIL above_rdata got %h want 0", rd); end
        xfer(1'b1, 32'h1012, 32'h12345678, 4'd0, 1'b0);
        checks++; if (se !== 1'b1)    begin errors++; $display("FAIL misalign_slverr got %b want 1", se); end
        xfer(1'b0, 32'h0FFC, 32'h0, 4'd1, 1'b0);
        checks++; if (se !== 1'b1)    begin errors++; $display("FAIL below_slverr got %b want 1", se); end
        xfer(1'b0, 32'h1010, 32'h0, 4'd0, 1'b0);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL misalign_unchanged got %h want deadbeef", rd); end
        checks++; if (se !== 1'b0)    begin errors++; $display("FAIL ok_after_err got %b want 0", se); end
        xfer(1'b1, 32'h13FC, 32'hA5A5A5A5, 4'd0, 1'b0);
        checks++; if (se !== 1'b0)    begin errors++; $display("FAIL top_wr_slverr got %b want 0", se); end
        xfer(1'b0, 32'h13FC, 32'h0, 4'd0, 1'b0);
        checks++; if (rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL top_rd got %h want a5a5a5a5", rd); end
    endtask

    task automatic test_err_inject();
        xfer(1'b1, 32'h1010, 32'hCAFEF00D, 4'd0, 1'b1);
        checks++; if (se !== 1'b1) begin errors++; $display("FAIL inject_slverr got %b want 1", se); end
        xfer(1'b0, 32'h1010, 32'h0, 4'd0, 1'b0);
        checks++; if (se !== 1'b0) begin errors++; $display("FAIL inject_late_ignored got %b want 0", se); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL inject_unchanged got %h want deadbeef", rd); end
        @(posedge clk); #1;
        checks++; if (access_cnt !== exp_cnt) begin errors++; $display("FAIL cnt_with_errors got %0d want %0d", access_cnt, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        xfer(1'b1, 32'h1020, 32'h01234567, 4'd0, 1'b0);
        xfer(1'b0, 32'h1020, 32'h0, 4'd0, 1'b0);
        checks++; if (rd !== 32'h01234567) begin errors++; $display("FAIL b2b_rd1 got %h want 01234567", rd); end
        xfer(1'b1, 32'h1024, 32'h89ABCDEF, 4'd2, 1'b0);
        xfer(1'b0, 32'h1024, 32'h0, 4'd0, 1'b0);
        checks++; if (rd !== 32'h89ABCDEF) begin errors++; $display("FAIL b2b_rd2 got %h want 89abcdef", rd); end
        checks++; if (cyc != 2) begin errors++; $display("FAIL b2b_len got %0d want 2", cyc); end
        xfer(1'b0, 32'h1020, 32'h0, 4'd0, 1'b0);
        checks++; if (rd !== 32'h01234567) begin errors++; $display("FAIL b2b_rd3 got %h want 01234567", rd); end
    endtask

`ifdef APB_SLV_PSTRB_EN
    task automatic test_strobe();
        tb_strb = 4'b1111;
        xfer(1'b1, 32'h1040, 32'hFFFFFFFF, 4'd0, 1'b0);
        tb_strb = 4'b0101;
        xfer(1'b1, 32'h1040, 32'h00000000, 4'd0, 1'b0);
        tb_strb = 4'b0000;
        xfer(1'b1, 32'h1040, 32'h12345678, 4'd1, 1'b0);
        checks++; if (se !== 1'b0) begin errors++; $display("FAIL strb0_slverr got %b want 0", se); end
        xfer(1'b0, 32'h1040, 32'h0, 4'd0, 1'b0);
        checks++; if (rd !== 32'hFF00FF00) begin errors++; $display("FAIL strb_rd got %h want ff00ff00", rd); end
        tb_strb = 4'b1111;
    endtask
`endif

    task automatic test_abort();
        xfer(1'b1, 32'h1030, 32'h00000000, 4'd0, 1'b0);
        // psel dropped while waiting
        @(negedge clk);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = 32'h1030; bus.pwdata = 32'h11111111;
        wait_cfg = 4'd5; err_inject = 1'b0;
        @(negedge clk);
        bus.penable = 1'b1;
        repeat (2) @(negedge clk);
        bus.psel = 1'b0; bus.penable = 1'b0;
        #1;
        checks++; if (bus.pready !== 1'b0) begin errors++; $display("FAIL abort_pready got %b want 0", bus.pready); end
        xfer(1'b0, 32'h1030, 32'h0, 4'd0, 1'b0);
        checks++; if (cyc != 2) begin errors++; $display("FAIL abort_idle_len got %0d want 2", cyc); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL abort_nowrite got %h want 0", rd); end
        @(posedge clk); #1;
        checks++; if (access_cnt !== exp_cnt) begin errors++; $display("FAIL abort_nocount got %0d want %0d", access_cnt, exp_cnt); end
        // reset hits on the completing edge of a write
        @(negedge clk);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = 32'h1030; bus.pwdata = 32'h22222222;
        wait_cfg = 4'd0; err_inject = 1'b0;
        @(negedge clk);
        bus.penable = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.psel = 1'b0; bus.penable = 1'b0;
        exp_cnt = 16'h0;
        #1;
        checks++; if (access_cnt !== 16'h0) begin errors++; $display("FAIL rst_mid_cnt got %0d want 0", access_cnt); end
        checks++; if (bus.pready !== 1'b0)  begin errors++; $display("FAIL rst_mid_pready got %b want 0", bus.pready); end
        xfer(1'b0, 32'h1030, 32'h0, 4'd0, 1'b0);
        checks++; if (cyc != 2)       begin errors++; $display("FAIL rst_mid_len got %0d want 2", cyc); end
        checks++; if (rd !== 32'h0)   begin errors++; $display("FAIL rst_mid_nowrite got %h want 0", rd); end
        @(posedge clk); #1;
        checks++; if (access_cnt !== 16'd1) begin errors++; $display("FAIL rst_mid_recount got %0d want 1", access_cnt); end
    endtask

    task automatic test_saturation();
        go_idle();
        force dut.access_cnt = 16'hFFFD;
        #1;
        release dut.access_cnt;
        exp_cnt = 16'hFFFD;
        for (int i = 0; i < 4; i++) begin
            xfer(1'b0, 32'h1010, 32'h0, 4'd0, 1'b0);
            @(posedge clk); #1;
            checks++; if (access_cnt !== exp_cnt) begin errors++; $display("FAIL sat_step%0d got %h want %h", i, access_cnt, exp_cnt); end
        end
        checks++; if (access_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_final got %h want ffff", access_cnt); end
        go_idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_cnt = 16'h0;
        rst = 1'b1;
        wait_cfg = 4'd0;
        err_inject = 1'b0;
        bus.psel = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite = 1'b0;
        bus.paddr = 32'h0;
        bus.pwdata = 32'h0;
        rd = 32'h0;
        se = 1'b0;
        cyc = 0;
        low = 0;
`ifdef APB_SLV_PSTRB_EN
        tb_strb = 4'b1111;
        bus.pstrb = 4'b1111;
`endif
        test_reset();
        test_write_read();
        test_wait_states();
        test_decode_err();
        test_err_inject();
        test_back_to_back();
`ifdef APB_SLV_PSTRB_EN
        test_strobe();
`endif
        test_abort();
        test_saturation();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
